// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer sitting directly behind the UART receiver. Every
// completed byte (rx_end pulse with rx_data) is pushed into a circular FIFO.
// The bus side pops one byte per accepted rd_en. The read data is registered
// and is presented with a one-cycle rd_valid pulse. The block also provides:
//   - occupancy status: empty, full and count
//   - a sticky overrun flag for bytes dropped while the FIFO was full
//   - a fill-level interrupt, thr_irq
//   - an idle-line timeout interrupt, to_irq, raised when data has been
//     waiting for TIMEOUT cycles with the line quiet and no FIFO traffic
// There is a single clock domain. The control logic is built from pointers
// and counters only; there is no FSM.
//
// Parameters
//   DEPTH     FIFO entries, must equal 2**ADDR_W
//   ADDR_W    pointer width
//   DATA_W    byte width
//   THRESH    thr_irq level, 1..DEPTH
//   TIMEOUT   idle cycles before to_irq
//   TO_CNT_W  timeout counter width, must be able to hold TIMEOUT
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   rx_end    in   1-cycle strobe: rx_data holds a completed byte
//   rx_data   in   received byte
//   rx_busy   in   receiver is mid-frame (line active)
//   rd_en     in   bus-side read request, one byte per cycle
//   rd_data   out  registered read byte, valid while rd_valid is high
//   rd_valid  out  pulses one cycle after an accepted read
//   empty     out  count == 0
//   full      out  count == DEPTH
//   count     out  bytes stored, 0..DEPTH
//   ovr_err   out  sticky: a byte arrived while full and was dropped
//   ovr_clr   in   clears ovr_err (a same-cycle overrun wins)
//   flush     in   discards all contents; ovr_err is kept
//   thr_irq   out  count >= THRESH
//   to_irq    out  data has been waiting with the line idle for TIMEOUT cycles
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int THRESH   = 8,
  parameter int TIMEOUT  = 4096,
  parameter int TO_CNT_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_end,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_busy,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              ovr_err,
  input  logic              ovr_clr,
  input  logic              flush,
  output logic              thr_irq,
  output logic              to_irq
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_THR  = (ADDR_W+1)'(THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [TO_CNT_W-1:0] TO_MAX = TO_CNT_W'(TIMEOUT);
  localparam logic [TO_CNT_W-1:0] TO_ONE = TO_CNT_W'(1);

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count_q;
  logic [TO_CNT_W-1:0] to_cnt;

  logic rd_acc;
  logic wr_acc;
  logic ovr_set;
  logic to_clear;

  // --------------------------------------------------------------------------
  // Status, derived combinationally from the occupancy counter
  // --------------------------------------------------------------------------
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign thr_irq = (count_q >= CNT_THR);
  assign to_irq  = (to_cnt == TO_MAX);

  // --------------------------------------------------------------------------
  // Transfer qualification. While flush is high, the bus and receiver
  // strobes are ignored. When the FIFO is full, a write is still accepted if
  // a read frees a slot in the same cycle. When the FIFO is empty, a
  // same-cycle read is refused: there is no bypass path, so the new byte
  // becomes readable on the next cycle.
  // --------------------------------------------------------------------------
  assign rd_acc  = rd_en  && !empty && !flush;
  assign wr_acc  = rx_end && (!full || rd_acc) && !flush;
  assign ovr_set = rx_end && full && !rd_acc && !flush;

  // Any FIFO activity, an active line, or nothing stored restarts the
  // idle timer.
  assign to_clear = empty || rx_busy || wr_acc || rd_acc;

  // --------------------------------------------------------------------------
  // Storage array
  // NOTE: the array has no reset. Entries are only ever read after they have
  // been written, so clearing them would cost reset fan-out for nothing.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and read port
  // NOTE: all clocked state is updated with non-blocking assignments. As a
  // result, the read below samples mem[rd_ptr] before a same-cycle write to
  // that slot lands, which gives full-FIFO read-before-write for free.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;

      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end

      // A simultaneous push and pop leave the occupancy unchanged.
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overrun flag. A flush leaves it alone. If an overrun happens in
  // the same cycle as ovr_clr, the set takes priority so the event is not
  // lost.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_err <= 1'b0;
    end else if (ovr_set) begin
      ovr_err <= 1'b1;
    end else if (ovr_clr) begin
      ovr_err <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Idle-line timeout counter. It saturates at TIMEOUT, so to_irq stays high
  // until a clearing event occurs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush || to_clear) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_ONE;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo. The stimulus tasks keep a byte-queue
// model of the FIFO contents. For every read the FIFO should accept, the
// model pushes the expected byte onto exp_q. A separate monitor pops exp_q
// whenever the DUT raises rd_valid and compares the popped byte with rd_data.
// Status outputs are compared against hand-computed constants.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_end;
  logic [7:0] rx_data;
  logic       rx_busy;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovr_err;
  logic       ovr_clr;
  logic       flush;
  logic       thr_irq;
  logic       to_irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH(16), .ADDR_W(4), .DATA_W(8), .THRESH(8), .TIMEOUT(4096), .TO_CNT_W(13)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_end  (rx_end),
    .rx_data (rx_data),
    .rx_busy (rx_busy),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovr_err (ovr_err),
    .ovr_clr (ovr_clr),
    .flush   (flush),
    .thr_irq (thr_irq),
    .to_irq  (to_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: rd_valid is sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_valid_unexpected: got rd_data=0x%0h, expected no read (t=%0t)",
                 rd_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", {24'd0, rd_data}, {24'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one cycle with the given strobes. The model decides what the FIFO
  // should accept, following the FIFO's acceptance rules: reads need data;
  // writes need space, or a same-cycle read that frees a slot.
  task automatic step(input bit we, input logic [7:0] d, input bit re);
    bit ra;
    bit wa;
    rx_end  = we;
    rx_data = d;
    rd_en   = re;
    ra = re && (mq.size() != 0);
    wa = we && ((mq.size() < DEPTH) || ra);
    if (ra) exp_q.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    tick();
    rx_end = 1'b0;
    rd_en  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},    {31'd0, empty},    32'd1);
    check({tag, "_full"},     {31'd0, full},     32'd0);
    check({tag, "_count"},    {27'd0, count},    32'd0);
    check({tag, "_ovr_err"},  {31'd0, ovr_err},  32'd0);
    check({tag, "_thr_irq"},  {31'd0, thr_irq},  32'd0);
    check({tag, "_to_irq"},   {31'd0, to_irq},   32'd0);
    check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_rd_data"},  {24'd0, rd_data},  32'd0);
  endtask

  // Counts idle cycles until to_irq rises. The wait is bounded; 0 means
  // to_irq never rose within the bound.
  task automatic wait_to_irq(output int first);
    first = 0;
    for (int k = 1; k <= TIMEOUT + 16 && first == 0; k++) begin
      tick();
      if (to_irq) first = k;
    end
  endtask

  initial begin
    int first;
    int hits;

    reset   = 1'b1;
    rx_end  = 1'b0;
    rx_data = 8'h00;
    rx_busy = 1'b0;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
    flush   = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // 1: basic write, then read in order
    step(1, 8'h41, 0);
    check("t1_empty_after_1st", {31'd0, empty}, 32'd0);
    step(1, 8'h42, 0);
    step(1, 8'h43, 0);
    check("t1_count3", {27'd0, count}, 32'd3);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    check("t1_count0", {27'd0, count}, 32'd0);
    check("t1_empty", {31'd0, empty}, 32'd1);
    tick();
    check("t1_rd_valid_low", {31'd0, rd_valid}, 32'd0);
    check("t1_rd_data_held", {24'd0, rd_data}, 32'h43);
    step(0, 8'h00, 1);  // read while empty is ignored
    check("t1_underflow_valid", {31'd0, rd_valid}, 32'd0);
    check("t1_underflow_count", {27'd0, count}, 32'd0);

    // 2: fill, overrun on the 17th byte, drain, clear overrun
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    check("t2_full", {31'd0, full}, 32'd1);
    check("t2_ovr_before", {31'd0, ovr_err}, 32'd0);
    step(1, 8'h10, 0);
    check("t2_ovr_set", {31'd0, ovr_err}, 32'd1);
    check("t2_count16", {27'd0, count}, 32'd16);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
    check("t2_empty", {31'd0, empty}, 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("t2_ovr_clr", {31'd0, ovr_err}, 32'd0);

    // 3: simultaneous read and write when full, then when empty
    for (int i = 0; i < 16; i++) step(1, 8'(8'h50 + i), 0);
    step(1, 8'hAA, 1);
    check("t3_count_full_rw", {27'd0, count}, 32'd16);
    check("t3_ovr_full_rw", {31'd0, ovr_err}, 32'd0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
    check("t3_drained", {31'd0, empty}, 32'd1);
    step(1, 8'h77, 1);
    check("t3_empty_rw_valid", {31'd0, rd_valid}, 32'd0);
    check("t3_empty_rw_count", {27'd0, count}, 32'd1);
    step(0, 8'h00, 1);

    // 4: threshold interrupt, then streaming across the pointer wrap
    for (int i = 0; i < 7; i++) step(1, 8'(8'hC0 + i), 0);
    check("t4_thr_7", {31'd0, thr_irq}, 32'd0);
    step(1, 8'hC7, 0);
    check("t4_thr_8", {31'd0, thr_irq}, 32'd1);
    step(0, 8'h00, 1);
    check("t4_thr_after_read", {31'd0, thr_irq}, 32'd0);
    for (int i = 0; i < 40; i++) step(1, 8'(8'h80 + i), 1);
    check("t4_count_stream", {27'd0, count}, 32'd7);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 1);
    check("t4_empty", {31'd0, empty}, 32'd1);

    // 5: idle timeout
    step(1, 8'h33, 0);
    wait_to_irq(first);
    check("t5_to_latency", first, TIMEOUT);
    rx_busy = 1'b1;
    tick();
    rx_busy = 1'b0;
    check("t5_to_drop_busy", {31'd0, to_irq}, 32'd0);
    wait_to_irq(first);
    check("t5_to_recount", first, TIMEOUT);
    step(0, 8'h00, 1);
    check("t5_to_drop_read", {31'd0, to_irq}, 32'd0);
    hits = 0;
    for (int k = 0; k < TIMEOUT + 200; k++) begin
      tick();
      if (to_irq) hits++;
    end
    check("t5_to_while_empty", hits, 0);

    // 6: flush keeps ovr_err; reset mid-stream
    for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0);
    step(1, 8'h70, 0);
    for (int i = 0; i < 11; i++) step(0, 8'h00, 1);
    check("t6_count5", {27'd0, count}, 32'd5);
    check("t6_ovr_pre", {31'd0, ovr_err}, 32'd1);
    flush   = 1'b1;
    rx_end  = 1'b1;
    rx_data = 8'h99;
    rd_en   = 1'b1;
    tick();
    flush  = 1'b0;
    rx_end = 1'b0;
    rd_en  = 1'b0;
    mq.delete();
    check("t6_flush_count", {27'd0, count}, 32'd0);
    check("t6_flush_empty", {31'd0, empty}, 32'd1);
    check("t6_flush_valid", {31'd0, rd_valid}, 32'd0);
    check("t6_flush_rd_data", {24'd0, rd_data}, 32'd0);
    check("t6_flush_ovr", {31'd0, ovr_err}, 32'd1);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hE0 + i), 0);
    step(0, 8'h00, 1);
    reset   = 1'b1;
    rx_end  = 1'b1;
    rx_data = 8'h55;
    rd_en   = 1'b1;
    tick();
    rx_end = 1'b0;
    rd_en  = 1'b0;
    mq.delete();
    check_reset_state("t6_reset");
    reset = 1'b0;
    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
